// File: rtl/bit_insertion_16x32_seq.sv
// Fragment merger for the egress path. Places 16-bit fragments into a 32-bit word at
// offset k+1 and flushes the word downstream with a written-bit mask.
module bit_insertion_16x32_seq #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned IN_DATA_WIDTH = DATA_WIDTH >> 1,
  parameter int unsigned COMMAND_WIDTH = $clog2(DATA_WIDTH) - 1,
  parameter int unsigned MAX_FRAGS     = 4,
  parameter int unsigned CNT_WIDTH     = $clog2(MAX_FRAGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [IN_DATA_WIDTH-1:0] i_data_bus,
  input  logic                     i_en,
  input  logic [COMMAND_WIDTH-1:0] i_cmd,
  input  logic                     i_last,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [DATA_WIDTH-1:0]    o_data_bus,
  output logic [DATA_WIDTH-1:0]    o_mask,
  output logic [CNT_WIDTH-1:0]     o_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [COMMAND_WIDTH:0] SHIFT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = 1;
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = CNT_WIDTH'(MAX_FRAGS);
  localparam int unsigned            PAD_WIDTH = DATA_WIDTH - IN_DATA_WIDTH;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_data, acc_mask;
  logic [DATA_WIDTH-1:0]   win_data, win_mask;
  logic [CNT_WIDTH-1:0]    count;
  logic [COMMAND_WIDTH:0]  shamt;
  logic                    acc, drain, cnt_full;

  assign i_ready = (state_q == ACCUM);
  assign o_valid = (state_q == FLUSH);

  assign acc      = i_valid & i_ready & i_en;
  assign drain    = o_valid & o_ready;
  assign cnt_full = ((count + CNT_ONE) == CNT_MAX);

  // Offset is k+1 so bit 0 is never covered by any window.
  assign shamt    = {1'b0, i_cmd} + SHIFT_ONE;
  assign win_mask = {{PAD_WIDTH{1'b0}}, {IN_DATA_WIDTH{1'b1}}} << shamt;
  assign win_data = {{PAD_WIDTH{1'b0}}, i_data_bus} << shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (acc && (i_last || cnt_full)) state_d = FLUSH;
      FLUSH:   if (o_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data <= '0;
      acc_mask <= '0;
      count    <= '0;
    end else if (drain) begin
      acc_data <= '0;
      acc_mask <= '0;
      count    <= '0;
    end else if (acc) begin
      acc_data <= (acc_data & ~win_mask) | win_data;
      acc_mask <= acc_mask | win_mask;
      count    <= count + CNT_ONE;
    end
  end

  assign o_data_bus = acc_data;
  assign o_mask     = acc_mask;
  assign o_count    = count;

endmodule

// File: tb/tb_bit_insertion_16x32_seq.sv
// Bench for bit_insertion_16x32_seq: directed scenarios plus randomized traffic
// checked against a bit-level model of the merge rules.
module tb_bit_insertion_16x32_seq;

  localparam int MAX_FRAGS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, i_en, i_last;
  logic [15:0] i_data_bus;
  logic [3:0]  i_cmd;
  logic        o_valid, o_ready;
  logic [31:0] o_data_bus, o_mask;
  logic [2:0]  o_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_data, m_mask;
  int          m_count;
  bit          m_flush;

  bit_insertion_16x32_seq #(
    .DATA_WIDTH(32),
    .MAX_FRAGS(MAX_FRAGS)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_data_bus(i_data_bus),
    .i_en(i_en), .i_cmd(i_cmd), .i_last(i_last),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_data_bus(o_data_bus), .o_mask(o_mask), .o_count(o_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [68:0] exp_vec();
    return {m_flush, !m_flush, 3'(m_count), m_mask, m_data};
  endfunction

  function automatic logic [68:0] obs_vec();
    return {o_valid, i_ready, o_count, o_mask, o_data_bus};
  endfunction

  // Selector view: the 16 bits starting at position k+1.
  function automatic logic [15:0] sel(input logic [31:0] w, input int k);
    logic [15:0] r;
    for (int j = 0; j < 16; j++) r[j] = w[k + 1 + j];
    return r;
  endfunction

  task automatic model_clear();
    m_data = '0; m_mask = '0; m_count = 0; m_flush = 0;
  endtask

  // Called at a falling edge; returns at the next falling edge with i_valid low.
  task automatic beat(input logic [15:0] d, input logic [3:0] k, input logic last, input logic en);
    bit rdy;
    i_valid = 1'b1; i_data_bus = d; i_cmd = k; i_last = last; i_en = en;
    rdy = i_ready;
    @(posedge clk);
    if (rdy && en) begin
      for (int j = 0; j < 16; j++) begin
        m_data[int'(k) + 1 + j] = d[j];
        m_mask[int'(k) + 1 + j] = 1'b1;
      end
      m_count++;
      if (last || m_count == MAX_FRAGS) m_flush = 1;
    end
    @(negedge clk);
    i_valid = 1'b0; i_en = 1'b0; i_last = 1'b0;
  endtask

  task automatic handshake();
    bit v;
    o_ready = 1'b1;
    v = o_valid;
    @(posedge clk);
    if (v) model_clear();
    @(negedge clk);
    o_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 0; i_en = 0; i_last = 0; i_data_bus = '0; i_cmd = '0; o_ready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (obs_vec() !== exp_vec() || o_valid !== 1'b0 || i_ready !== 1'b1) begin
      bad++; $display("FAIL reset: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    beat(16'h0408, 4'd0, 1'b0, 1'b1);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL basic_beat1: got %h want %h", obs_vec(), exp_vec());
    end
    beat(16'hA442, 4'd15, 1'b1, 1'b1);
    total++;
    if (obs_vec() !== exp_vec() || o_data_bus !== 32'hA4420810 || o_mask !== 32'hFFFFFFFE
        || o_count !== 3'd2 || o_valid !== 1'b1) begin
      bad++; $display("FAIL basic_flush: got %h want %h", obs_vec(), exp_vec());
    end
    total++;
    if (sel(o_data_bus, 0) !== 16'h0408 || sel(o_data_bus, 15) !== 16'hA442) begin
      bad++; $display("FAIL basic_roundtrip: got %h/%h want 0408/a442",
                      sel(o_data_bus, 0), sel(o_data_bus, 15));
    end
    handshake();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL basic_drain: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_overlap();
    beat(16'hFFFF, 4'd0, 1'b0, 1'b1);
    beat(16'h0000, 4'd7, 1'b1, 1'b1);
    total++;
    if (obs_vec() !== exp_vec() || o_data_bus !== 32'h000000FE || o_mask !== 32'h00FFFFFE
        || o_count !== 3'd2) begin
      bad++; $display("FAIL overlap: got %h want %h", obs_vec(), exp_vec());
    end
    handshake();
  endtask

  task automatic test_max_frags();
    logic [68:0] snap;
    beat(16'h1111, 4'd0, 1'b0, 1'b1);
    beat(16'h2222, 4'd3, 1'b0, 1'b1);
    beat(16'h3333, 4'd8, 1'b0, 1'b1);
    total++;
    if (obs_vec() !== exp_vec() || o_valid !== 1'b0) begin
      bad++; $display("FAIL max_pre: got %h want %h", obs_vec(), exp_vec());
    end
    beat(16'h4444, 4'd15, 1'b0, 1'b1);
    total++;
    if (obs_vec() !== exp_vec() || o_valid !== 1'b1 || o_count !== 3'd4) begin
      bad++; $display("FAIL max_flush: got %h want %h", obs_vec(), exp_vec());
    end
    snap = exp_vec();
    beat(16'h5555, 4'd2, 1'b1, 1'b1);
    total++;
    if (obs_vec() !== snap || i_ready !== 1'b0) begin
      bad++; $display("FAIL max_fifth_blocked: got %h want %h", obs_vec(), snap);
    end
    handshake();
  endtask

  task automatic test_backpressure_en();
    logic [68:0] snap;
    beat(16'hBEEF, 4'd5, 1'b1, 1'b0);
    total++;
    if (obs_vec() !== exp_vec() || o_count !== 3'd0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL en_low_dropped: got %h want %h", obs_vec(), exp_vec());
    end
    beat(16'hC3A5, 4'd9, 1'b0, 1'b1);
    beat(16'h7E81, 4'd1, 1'b1, 1'b1);
    snap = exp_vec();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (obs_vec() !== snap || i_ready !== 1'b0) begin
        bad++; $display("FAIL hold_cycle%0d: got %h want %h", c, obs_vec(), snap);
      end
    end
    total++;
    if (i_ready !== 1'b0) begin
      bad++; $display("FAIL handshake_bubble: i_ready got %b want 0", i_ready);
    end
    handshake();
    total++;
    if (i_ready !== 1'b1 || o_count !== 3'd0 || o_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL after_handshake: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_in_flush();
    beat(16'h9999, 4'd4, 1'b1, 1'b1);
    total++;
    if (o_valid !== 1'b1) begin
      bad++; $display("FAIL rstflush_setup: o_valid got %b want 1", o_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (o_valid !== 1'b0 || o_data_bus !== 32'h0 || o_mask !== 32'h0 || o_count !== 3'd0) begin
      bad++; $display("FAIL rst_async: got v=%b d=%h m=%h c=%0d want 0", o_valid, o_data_bus, o_mask, o_count);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    beat(16'h0001, 4'd0, 1'b1, 1'b1);
    total++;
    if (obs_vec() !== exp_vec() || o_data_bus !== 32'h00000002) begin
      bad++; $display("FAIL rst_then_beat: got %h want %h", obs_vec(), exp_vec());
    end
    handshake();
  endtask

  task automatic test_random();
    logic [68:0] snap;
    for (int n = 0; n < 300; n++) begin
      if (m_flush) begin
        snap = exp_vec();
        repeat ($urandom_range(0, 2)) begin
          beat(16'($urandom), 4'($urandom), 1'($urandom), 1'b1);
          total++;
          if (obs_vec() !== snap) begin
            bad++; $display("FAIL rand_stall n=%0d: got %h want %h", n, obs_vec(), snap);
          end
        end
        handshake();
      end else begin
        beat(16'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
      end
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL rand_step n=%0d: got %h want %h", n, obs_vec(), exp_vec());
      end
    end
    if (m_flush) handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_max_frags();
    test_backpressure_en();
    test_reset_in_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
